seven_seg_scan: RTL

- Upstream stage of the registered BCD-to-7-segment decoder. Time-multiplexes NUM_DIGITS BCD digits onto one 4-bit digit bus D and drives active-low digit enables for the board's common-anode display.
- Inserts a blanking guard between digits to prevent ghosting.
- Compensates for the decoder's one-cycle register latency.
- Accepts new display values with a load strobe; commits them only at frame boundaries so a frame never mixes old and new digits.

---
 rtl/seven_seg_scan_pkg.sv | 12 +
 rtl/seven_seg_scan_timer.sv | 63 ++++++
 rtl/seven_seg_scan.sv | 96 +++++++++
 3 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and slot-state encoding for the seven_seg_scan digit multiplexer.
package seven_seg_scan_pkg;

  localparam int NIB_W = 4;
  localparam logic [NIB_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot/digit counters for seven_seg_scan; exposes next-cycle values so the top
// can register outputs that line up with the counter state they describe.
//
//   state | meaning
//   GUARD | cnt 0..BLANK_CYCLES-1, all digit enables off, D blank
//   SHOW  | cnt BLANK_CYCLES..REFRESH_DIV-1, digit idx driven on D
module seven_seg_scan_timer
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output slot_state_t   o_state_nxt,
  output logic [IW-1:0] o_idx_nxt,
  output logic          o_en_win_nxt,
  output logic          o_commit,
  output logic          o_frame_nxt
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  slot_state_t   r_state, w_state_nxt;
  logic          w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= GUARD;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_wrap      = (r_cnt == CNT_LAST);
    w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    if (w_wrap) w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? GUARD : SHOW;
  end

  // Enables open only after one full SHOW cycle, covering the decoder's register stage.
  always_comb begin
    o_state_nxt  = w_state_nxt;
    o_idx_nxt    = w_idx_nxt;
    o_en_win_nxt = (w_state_nxt == SHOW) && (r_state == SHOW);
    o_commit     = w_wrap && (r_idx == IDX_LAST);
    o_frame_nxt  = o_commit;
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed BCD digit scanner with frame-synchronous value commit.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load,
  input  logic [NIB_W*NUM_DIGITS-1:0] i_value,
  output logic [NIB_W-1:0]            o_d,
  output logic [NUM_DIGITS-1:0]       o_en,
  output logic                        o_frame
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = NIB_W * NUM_DIGITS;

  slot_state_t         w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_en_win_nxt, w_commit, w_frame_nxt;
  logic [VW-1:0]       r_pend, r_active;
  logic                r_pend_flag;
  logic [NUM_DIGITS-1:0] w_sup, w_en_nxt;
  logic [NIB_W-1:0]    w_nib, w_d_nxt;
  logic                w_shown;

  seven_seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_state_nxt (w_state_nxt),
    .o_idx_nxt   (w_idx_nxt),
    .o_en_win_nxt(w_en_win_nxt),
    .o_commit    (w_commit),
    .o_frame_nxt (w_frame_nxt)
  );

  // A load landing on the commit edge goes straight to active.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
      r_active    <= '0;
    end else if (w_commit) begin
      if (i_load)           r_active <= i_value;
      else if (r_pend_flag) r_active <= r_pend;
      r_pend_flag <= 1'b0;
    end else if (i_load) begin
      r_pend      <= i_value;
      r_pend_flag <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_zero_run;
`endif

  always_comb begin
    w_sup = '0;
`ifdef LEADING_ZERO_BLANK_EN
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (r_active[i*NIB_W +: NIB_W] == '0);
      w_sup[i]   = w_zero_run;
    end
`endif
  end

  always_comb begin
    w_nib    = r_active[int'(w_idx_nxt)*NIB_W +: NIB_W];
    w_shown  = !w_sup[w_idx_nxt];
    w_d_nxt  = (w_state_nxt == SHOW && w_shown) ? w_nib : BLANK_CODE;
    w_en_nxt = '1;
    if (w_en_win_nxt && w_shown) w_en_nxt[w_idx_nxt] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_d     <= BLANK_CODE;
      o_en    <= '1;
      o_frame <= 1'b0;
    end else begin
      o_d     <= w_d_nxt;
      o_en    <= w_en_nxt;
      o_frame <= w_frame_nxt;
    end
  end

endmodule
